pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_fwd_unit.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline hazard controller.
//   - mc_state_t     : multicycle-unit handshake FSM states
//   - FWD_RF/MEM/WB  : operand-forwarding select encodings
//   - MC_TIMEOUT_DEF : default multicycle wait limit in cycles
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } mc_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int unsigned MC_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipe_fwd_unit.sv
// pipe_fwd_unit: operand forwarding select for one EX source operand.
// Ports:
//   rs            in  REG_AW  EX source register
//   mem_rd        in  REG_AW  EX/MEM destination register
//   mem_reg_write in  1       EX/MEM writes a register
//   wb_rd         in  REG_AW  MEM/WB destination register
//   wb_reg_write  in  1       MEM/WB writes a register
//   fwd           out 2       FWD_RF / FWD_MEM / FWD_WB
// The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
module pipe_fwd_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      fwd = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, stall/flush generation, operand
// forwarding and multicycle-unit handshake for a 5-stage pipeline.
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   id_rs1, id_rs2               ID-stage source registers
//   ex_rs1, ex_rs2, ex_rd        EX-stage sources / destination
//   ex_mem_read, ex_mc_op        EX instruction is a load / multicycle op
//   ex_branch_taken              redirect resolved in EX
//   mem_rd, mem_reg_write        EX/MEM destination
//   wb_rd, wb_reg_write          MEM/WB destination
//   mc_done                      multicycle result-valid pulse
//   mc_start, mc_busy            multicycle start pulse / FSM not idle (registered)
//   stall_if, stall_id, stall_ex hold PC, IF/ID, ID/EX
//   flush_id, flush_ex           zero IF/ID, ID/EX
//   bubble_mem                   load NOP into EX/MEM
//   fwd_a, fwd_b                 operand forwarding selects
//   mc_timeout_err               sticky multicycle timeout flag
//   perf_stall_cnt, perf_flush_cnt  saturating performance counters
// Build option: define PIPE_HAZARD_CTRL_PERF_EN to implement the perf
// counters; without it both counter ports are tied to zero.
// Priority of stall sources: multicycle > branch flush > load-use.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mc_op,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              mc_done,
  output logic              mc_start,
  output logic              mc_busy,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              bubble_mem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mc_timeout_err,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(MC_TIMEOUT - 1);

  mc_state_t  state;
  logic [7:0] wait_cnt;
  logic       mc_stall;
  logic       load_use;

  // Multicycle handshake FSM with registered mc_start / mc_busy / timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      mc_start       <= 1'b0;
      mc_busy        <= 1'b0;
      mc_timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mc_op) begin
            state    <= START;
            wait_cnt <= '0;
            mc_start <= 1'b1;
            mc_busy  <= 1'b1;
          end
        end
        START: begin
          mc_start <= 1'b0;
          state    <= mc_done ? RELEASE : WAIT;
        end
        WAIT: begin
          if (mc_done) begin
            state <= RELEASE;
          end else if (wait_cnt == WAIT_LAST) begin
            state          <= RELEASE;
            mc_timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RELEASE: begin
          state   <= IDLE;
          mc_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mc_start <= 1'b0;
          mc_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mc_stall = ((state == IDLE) && ex_mc_op) || (state == START) || (state == WAIT);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    bubble_mem = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    if (mc_stall) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      bubble_mem = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_a)
  );

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_b)
  );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if ((flush_id || flush_ex) && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Control outputs are packed as {stall_if, stall_id, stall_ex, bubble_mem,
// flush_id, flush_ex}; the DUT uses MC_TIMEOUT=8.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110001;
  localparam logic [5:0] C_MC   = 6'b111100;
  localparam logic [5:0] C_BR   = 6'b000011;

  logic        clk, rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_mem_read, ex_mc_op, ex_branch_taken;
  logic        mem_reg_write, wb_reg_write, mc_done;
  logic        mc_start, mc_busy, stall_if, stall_id, stall_ex;
  logic        flush_id, flush_ex, bubble_mem, mc_timeout_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  logic [5:0]  ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .MC_TIMEOUT(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_mc_op        (ex_mc_op),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .mc_done         (mc_done),
    .mc_start        (mc_start),
    .mc_busy         (mc_busy),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .bubble_mem      (bubble_mem),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .mc_timeout_err  (mc_timeout_err),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
  );

  assign ctrl = {stall_if, stall_id, stall_ex, bubble_mem, flush_id, flush_ex};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_mem_read, ex_mc_op, ex_branch_taken} = '0;
    {mem_reg_write, wb_reg_write, mc_done} = '0;

    // Reset state
    #3;
    chk("rst_busy", 32'(mc_busy), 32'd0);
    chk("rst_start", 32'(mc_start), 32'd0);
    chk("rst_err", 32'(mc_timeout_err), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("rst_pstall", perf_stall_cnt, 32'd0);
    chk("rst_pflush", perf_flush_cnt, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Load-use hazards: three stalls, x0 destination never stalls
    tick(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; #1;
    chk("lu_rs2", 32'(ctrl), 32'(C_LU));
    tick(); id_rs2 = 5'd0; id_rs1 = 5'd5; #1;
    chk("lu_rs1", 32'(ctrl), 32'(C_LU));
    tick(); ex_rd = 5'd31; id_rs1 = 5'd31; #1;
    chk("lu_r31", 32'(ctrl), 32'(C_LU));
    tick(); ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
    chk("lu_x0", 32'(ctrl), 32'(C_NONE));

    // Branch wins over a simultaneous load-use
    tick(); ex_rd = 5'd9; id_rs1 = 5'd9; ex_branch_taken = 1'b1; #1;
    chk("br_over_lu", 32'(ctrl), 32'(C_BR));

    // Matching registers without a load: no hazard; perf totals so far
    tick(); ex_branch_taken = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd3; id_rs1 = 5'd3; #1;
    chk("no_load", 32'(ctrl), 32'(C_NONE));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'd3);
    chk("perf_flush", perf_flush_cnt, 32'd4);
`else
    chk("perf_stall_off", perf_stall_cnt, 32'd0);
    chk("perf_flush_off", perf_flush_cnt, 32'd0);
`endif
    ex_rd = 5'd0; id_rs1 = 5'd0;

    // Forwarding
    mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; ex_rs2 = 5'd0;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1; #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'(2'b10));
    chk("fwd_b_x0", 32'(fwd_b), 32'(2'b00));
    mem_reg_write = 1'b0; #1;
    chk("fwd_a_wb", 32'(fwd_a), 32'(2'b01));
    ex_rs1 = 5'd0; #1;
    chk("fwd_a_rs0", 32'(fwd_a), 32'(2'b00));
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1; #1;
    chk("fwd_a_rd0", 32'(fwd_a), 32'(2'b00));
    ex_rs2 = 5'd4; mem_rd = 5'd4; wb_rd = 5'd4; #1;
    chk("fwd_b_mem", 32'(fwd_b), 32'(2'b10));
    mem_rd = 5'd6; #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'(2'b01));
    wb_reg_write = 1'b0; #1;
    chk("fwd_b_none", 32'(fwd_b), 32'(2'b00));
    {mem_rd, wb_rd, ex_rs2} = '0; mem_reg_write = 1'b0;

    // mc_done in IDLE is ignored
    tick(); mc_done = 1'b1; #1;
    chk("idle_done_ctrl", 32'(ctrl), 32'(C_NONE));
    tick(); mc_done = 1'b0; #1;
    chk("idle_done_busy", 32'(mc_busy), 32'd0);

    // Multicycle op, mc_done in third WAIT cycle
    tick(); ex_mc_op = 1'b1; #1;
    chk("mc_idle_ctrl", 32'(ctrl), 32'(C_MC));
    chk("mc_idle_start", 32'(mc_start), 32'd0);
    tick(); #1;
    chk("mc_start_pulse", 32'(mc_start), 32'd1);
    chk("mc_start_busy", 32'(mc_busy), 32'd1);
    chk("mc_start_ctrl", 32'(ctrl), 32'(C_MC));
    tick(); ex_branch_taken = 1'b1; #1;
    chk("mc_w0_start", 32'(mc_start), 32'd0);
    chk("mc_w0_br_supp", 32'(ctrl), 32'(C_MC));
    tick(); ex_branch_taken = 1'b0; #1;
    chk("mc_w1_ctrl", 32'(ctrl), 32'(C_MC));
    tick(); mc_done = 1'b1; #1;
    chk("mc_w2_ctrl", 32'(ctrl), 32'(C_MC));
    tick(); mc_done = 1'b0; #1;
    chk("mc_rel_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("mc_rel_busy", 32'(mc_busy), 32'd1);
    ex_mc_op = 1'b0;
    tick(); #1;
    chk("mc_end_busy", 32'(mc_busy), 32'd0);
    chk("mc_end_err", 32'(mc_timeout_err), 32'd0);

    // Timeout: 8 WAIT cycles without mc_done
    tick(); ex_mc_op = 1'b1; #1;
    tick(); #1;
    chk("to_start", 32'(mc_start), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk($sformatf("to_wait%0d_ctrl", i), 32'(ctrl), 32'(C_MC));
      chk($sformatf("to_wait%0d_err", i), 32'(mc_timeout_err), 32'd0);
    end
    tick(); #1;
    chk("to_rel_ctrl", 32'(ctrl), 32'(C_NONE));
    chk("to_rel_err", 32'(mc_timeout_err), 32'd1);
    ex_mc_op = 1'b0;
    tick(); #1;
    chk("to_idle_busy", 32'(mc_busy), 32'd0);
    tick(); #1;
    chk("to_sticky", 32'(mc_timeout_err), 32'd1);

    // Reset during WAIT abandons the operation
    tick(); ex_mc_op = 1'b1;
    tick(); tick(); tick(); #1;
    chk("rw_wait_busy", 32'(mc_busy), 32'd1);
    rst_n = 1'b0; ex_mc_op = 1'b0; #1;
    chk("rw_busy", 32'(mc_busy), 32'd0);
    chk("rw_err", 32'(mc_timeout_err), 32'd0);
    chk("rw_ctrl", 32'(ctrl), 32'(C_NONE));
    tick(); rst_n = 1'b1;
    tick(); #1;
    chk("rw_no_start0", 32'(mc_start), 32'd0);
    tick(); #1;
    chk("rw_no_start1", 32'(mc_start), 32'd0);
    chk("rw_idle_busy", 32'(mc_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
